imem_loader: RTL and testbench

- Instruction-side responder for the single-cycle core's fetch port: the core drives inst_addr, this block returns inst_data combinationally in the same cycle.
- Holds a word-organised program store that is filled at start-up from a byte-stream loader port, for example from a UART receiver.
- Holds the core in reset (cpu_rst) until loading completes.
- Also provides a reload request to re-enter loading without a global reset.

---
 rtl/cpu_pkg.sv | 6 +
 rtl/imem_ram.sv | 21 ++
 rtl/imem_loader.sv | 93 +++++++++
 tb/tb_imem_loader.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the core and its instruction store
package cpu_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
    typedef enum logic {LOAD, RUN} ld_state_t;
endpackage

// File: rtl/imem_ram.sv
// imem_ram: word store with one synchronous write port and one combinational read port
module imem_ram
    import cpu_pkg::XLEN;
#(
    parameter int DEPTH = 256,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [XLEN-1:0]   o_rdata
);
    logic [XLEN-1:0] r_mem [DEPTH];

    always_ff @(posedge clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader and combinational instruction fetch responder
module imem_loader
    import cpu_pkg::ld_state_t, cpu_pkg::LOAD, cpu_pkg::RUN, cpu_pkg::XLEN;
#(
    parameter int DEPTH = 256,
    parameter logic [XLEN-1:0] NOP_INST = cpu_pkg::NOP_INST,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [7:0]      ld_data,
    input  logic            ld_last,
    input  logic            reload,
    output logic            cpu_rst,
    output logic            ovf,
    input  logic [XLEN-1:0] inst_addr,
    output logic [XLEN-1:0] inst_data
);
    ld_state_t         r_state, w_next;
    logic [ADDR_W-1:0] r_waddr, w_idx;
    logic [ADDR_W:0]   r_len;
    logic [1:0]        r_bcnt;
    logic [23:0]       r_asm;
    logic              r_ovf, r_cpu_rst;
    logic              w_acc, w_wr, w_full, w_hit;
    logic [XLEN-1:0]   w_word, w_rdata;

    always_comb begin
        w_acc  = ld_valid && r_state == LOAD;
        w_wr   = w_acc && (ld_last || r_bcnt == 2'd3);
        w_full = w_acc && !ld_last && r_bcnt == 2'd3 && r_waddr == ADDR_W'(DEPTH - 1);
        // bytes not yet received in a short final word read as zero
        w_word = r_bcnt == 2'd0 ? {24'h0, ld_data} :
                 r_bcnt == 2'd1 ? {16'h0, ld_data, r_asm[7:0]} :
                 r_bcnt == 2'd2 ? {8'h0, ld_data, r_asm[15:0]} : {ld_data, r_asm};
        w_next = r_state == LOAD ? ((w_acc && ld_last) || w_full ? RUN : LOAD)
                                 : (reload ? LOAD : RUN);
        w_idx  = inst_addr[ADDR_W+1:2];
        w_hit  = inst_addr[1:0] == 2'b00 && inst_addr[XLEN-1:ADDR_W+2] == '0 &&
                 {1'b0, w_idx} < r_len;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= LOAD;
            r_waddr   <= '0;
            r_len     <= '0;
            r_bcnt    <= '0;
            r_asm     <= '0;
            r_ovf     <= 1'b0;
            r_cpu_rst <= 1'b1;
        end else begin
            r_state   <= w_next;
            r_cpu_rst <= r_state == LOAD || w_next == LOAD;
            if (r_state == RUN && reload) begin
                r_waddr <= '0;
                r_len   <= '0;
                r_bcnt  <= '0;
                r_asm   <= '0;
                r_ovf   <= 1'b0;
            end else if (w_acc) begin
                r_bcnt <= r_bcnt + 2'd1;
                case (r_bcnt)
                    2'd0:    r_asm[7:0]   <= ld_data;
                    2'd1:    r_asm[15:8]  <= ld_data;
                    2'd2:    r_asm[23:16] <= ld_data;
                    default: ;
                endcase
                if (w_wr) begin
                    r_waddr <= r_waddr + ADDR_W'(1);
                    r_len   <= r_len + (ADDR_W + 1)'(1);
                end
                if (w_full) r_ovf <= 1'b1;
            end
        end
    end

    imem_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_waddr),
        .i_wdata (w_word),
        .i_raddr (w_idx),
        .o_rdata (w_rdata)
    );

    assign ld_ready  = r_state == LOAD;
    assign cpu_rst   = r_cpu_rst;
    assign ovf       = r_ovf;
    assign inst_data = w_hit ? w_rdata : NOP_INST;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized scoreboard bench for imem_loader at DEPTH=256 and DEPTH=4
module tb_imem_loader;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2], ld_valid [2], ld_ready [2], ld_last [2], reload [2], cpu_rst [2], ovf [2];
    logic [7:0]  ld_data [2];
    logic [31:0] inst_addr [2], inst_data [2];

    imem_loader #(.DEPTH(256)) u_big (
        .clk(clk), .rst(rst[0]), .ld_valid(ld_valid[0]), .ld_ready(ld_ready[0]),
        .ld_data(ld_data[0]), .ld_last(ld_last[0]), .reload(reload[0]), .cpu_rst(cpu_rst[0]),
        .ovf(ovf[0]), .inst_addr(inst_addr[0]), .inst_data(inst_data[0])
    );
    imem_loader #(.DEPTH(4)) u_small (
        .clk(clk), .rst(rst[1]), .ld_valid(ld_valid[1]), .ld_ready(ld_ready[1]),
        .ld_data(ld_data[1]), .ld_last(ld_last[1]), .reload(reload[1]), .cpu_rst(cpu_rst[1]),
        .ovf(ovf[1]), .inst_addr(inst_addr[1]), .inst_data(inst_data[1])
    );

    // reference model: the accepted image as a byte list plus load/run status
    int         depth [2];
    logic [7:0] img [2][1024];
    int         n [2];
    bit         loading [2], m_ovf [2];
    int         run_edges [2];

    typedef struct { string nm; int k; int sel; logic [31:0] exp; } chk_t;
    chk_t sb [$];
    int vecs = 0, miss = 0;
    logic [7:0] q [$];

    function automatic logic [31:0] word_of(int k, int i);
        logic [31:0] w = '0;
        for (int b = 0; b < 4; b++)
            if (4 * i + b < n[k]) w[8*b +: 8] = img[k][4*i+b];
        return w;
    endfunction

    function automatic logic [31:0] exp_fetch(int k, logic [31:0] a);
        int len = loading[k] ? n[k] / 4 : (n[k] + 3) / 4;
        logic [31:0] idx = a >> 2;
        if (a[1:0] != 2'b00 || idx >= 32'(len)) return NOP;
        return word_of(k, int'(idx));
    endfunction

    function automatic void expect_(string nm, int k, int sel, logic [31:0] e);
        sb.push_back('{nm, k, sel, e});
    endfunction

    function automatic logic [31:0] raddr();
        logic [31:0] a = 32'($urandom_range(0, 15)) << 2;
        case ($urandom_range(0, 7))
            0: a[1:0] = 2'($urandom_range(1, 3));
            1: a = a | 32'h0000_1000;
            default: ;
        endcase
        return a;
    endfunction

    always @(negedge clk) begin : mon
        chk_t c;
        logic [31:0] act;
        while (sb.size() > 0) begin
            c = sb.pop_front();
            act = c.sel == 0 ? inst_data[c.k] : c.sel == 1 ? 32'(cpu_rst[c.k]) :
                  c.sel == 2 ? 32'(ld_ready[c.k]) : 32'(ovf[c.k]);
            vecs++;
            if (act !== c.exp) begin
                miss++;
                $display("FAIL %s dut%0d: got %h, want %h", c.nm, c.k, act, c.exp);
            end
        end
    end

    // one clock cycle on DUT k; expectations reflect the model before the edge
    task automatic put(int k, logic [7:0] d, bit last, bit v, logic [31:0] a, bit rl);
        bit pre_run = !loading[k];
        ld_valid[k] = v; ld_data[k] = d; ld_last[k] = last; inst_addr[k] = a; reload[k] = rl;
        expect_("ld_ready", k, 2, 32'(loading[k]));
        expect_("cpu_rst", k, 1, 32'(loading[k] || run_edges[k] == 0));
        expect_("ovf", k, 3, 32'(m_ovf[k]));
        expect_($sformatf("fetch_%h", a), k, 0, exp_fetch(k, a));
        if (v && loading[k] && !rst[k]) begin
            img[k][n[k]] = d;
            n[k]++;
            if (last) loading[k] = 1'b0;
            else if (n[k] == 4 * depth[k]) begin
                loading[k] = 1'b0;
                m_ovf[k] = 1'b1;
            end
            if (!loading[k]) run_edges[k] = 0;
        end
        if (rl && pre_run && !rst[k]) begin
            loading[k] = 1'b1; n[k] = 0; m_ovf[k] = 1'b0; run_edges[k] = 0;
        end
        @(posedge clk); #1;
        if (pre_run && !loading[k]) run_edges[k]++;
        ld_valid[k] = 1'b0; ld_last[k] = 1'b0; reload[k] = 1'b0;
    endtask

    task automatic idle(int k, logic [31:0] a);
        put(k, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, a, 1'b0);
    endtask

    task automatic fetch_const(int k, logic [31:0] a, logic [31:0] e);
        expect_($sformatf("const_%h", a), k, 0, e);
        idle(k, a);
    endtask

    task automatic do_reload(int k);
        put(k, 8'h00, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic stream(int k, bit with_last, bit gaps);
        for (int i = 0; i < q.size(); i++) begin
            while (gaps && $urandom_range(0, 2) == 0) idle(k, raddr());
            put(k, q[i], with_last && i == q.size() - 1, 1'b1, raddr(), 1'b0);
        end
    endtask

    task automatic do_rst(int k);
        rst[k] = 1'b1;
        loading[k] = 1'b1; n[k] = 0; m_ovf[k] = 1'b0; run_edges[k] = 0;
        idle(k, 32'h0);
        idle(k, 32'h4);
        rst[k] = 1'b0;
    endtask

    initial begin
        depth[0] = 256; depth[1] = 4;
        for (int k = 0; k < 2; k++) begin
            rst[k] = 1'b1; ld_valid[k] = 1'b0; ld_last[k] = 1'b0; reload[k] = 1'b0;
            ld_data[k] = 8'h0; inst_addr[k] = 32'h0;
            loading[k] = 1'b1; n[k] = 0; m_ovf[k] = 1'b0; run_edges[k] = 0;
        end
        @(posedge clk); #1;
        fetch_const(0, 32'h0, NOP);
        idle(1, 32'h0);
        rst[0] = 1'b0; rst[1] = 1'b0;

        q = '{8'h33, 8'h00, 8'hB5, 8'h00, 8'hB3, 8'h81, 8'h20, 8'h40};
        stream(0, 1'b1, 1'b0);
        fetch_const(0, 32'h0, 32'h00B5_0033);
        fetch_const(0, 32'h4, 32'h4020_81B3);
        fetch_const(0, 32'h8, NOP);
        expect_("cpu_rst_low", 0, 1, 32'h0);
        idle(0, raddr());

        do_reload(0);
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        stream(0, 1'b1, 1'b0);
        fetch_const(0, 32'h4, 32'h0000_0005);
        fetch_const(0, 32'h0, 32'h0403_0201);

        do_reload(0);
        do_reload(0);
        q.delete();
        for (int i = 0; i < $urandom_range(9, 40); i++) q.push_back(8'($urandom));
        stream(0, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) put(0, 8'($urandom), 1'b0, 1'($urandom_range(0, 1)), raddr(), 1'b0);
        fetch_const(0, 32'h2, NOP);
        fetch_const(0, 32'h0000_1000, NOP);

        do_reload(0);
        fetch_const(0, 32'h0, NOP);
        expect_("reload_ovf", 0, 3, 32'h0);
        expect_("reload_ready", 0, 2, 32'h1);
        idle(0, 32'h0);

        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        stream(0, 1'b0, 1'b1);
        fetch_const(0, 32'h0, 32'h4433_2211);
        do_rst(0);
        fetch_const(0, 32'h0, NOP);
        q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        stream(0, 1'b1, 1'b1);
        fetch_const(0, 32'h0, 32'hD4C3_B2A1);
        fetch_const(0, 32'h4, NOP);

        q.delete();
        for (int i = 0; i < 20; i++) q.push_back(8'(i + 1));
        stream(1, 1'b0, 1'b0);
        expect_("ovf_set", 1, 3, 32'h1);
        expect_("full_ready", 1, 2, 32'h0);
        fetch_const(1, 32'h0, 32'h0403_0201);
        fetch_const(1, 32'hC, 32'h100F_0E0D);
        fetch_const(1, 32'h10, NOP);
        do_reload(1);
        expect_("ovf_clear", 1, 3, 32'h0);
        idle(1, 32'h0);

        @(negedge clk); #1;
        if (sb.size() != 0) begin
            miss++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end
endmodule
